count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have one parameter: MARGIN, default 2, the number of extra decrement cycles tolerated beyond the requested value before an error is flagged (legal range 0..15).
REQ-002 The block SHALL have the port: clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have the port: req_valid  input  1  request to run one load/count-down sequence.
REQ-005 The block SHALL have the port: req_ready  output  1  block can accept a request.
REQ-006 The block SHALL have the port: req_value  input  4  count value to load, unsigned.
REQ-007 The block SHALL have the port: latch  output  1  load strobe to the external down counter.
REQ-008 The block SHALL have the port: dec  output  1  decrement enable to the external down counter.
REQ-009 The block SHALL have the port: zero  input  1  zero flag returned by the external down counter.
REQ-010 The block SHALL have the port: busy  output  1  a sequence is in progress.
REQ-011 The block SHALL have the port: done  output  1  one-cycle pulse on a correct sequence end.
REQ-012 The block SHALL have the port: error  output  1  one-cycle pulse on an early zero or a timeout.
REQ-013 The block SHALL have the port: cycles  output  5  number of dec cycles issued in the last sequence.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, SETTLE, COUNT, DONE and ERR.
REQ-015 In IDLE, req_ready SHALL be 1 and busy SHALL be 0; in every other state, req_ready SHALL be 0 and busy SHALL be 1.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 On acceptance, the block SHALL capture req_value into an internal 4-bit register, clear the internal 5-bit counter to 0, and go to LOAD.
REQ-018 The block SHALL ignore req_value changes after acceptance.
REQ-019 In LOAD, latch SHALL be 1 for exactly one cycle and dec SHALL be 0; the next state SHALL be SETTLE.
REQ-020 In SETTLE, latch SHALL be 0 and dec SHALL be 0 for one cycle; the next state SHALL be COUNT.
REQ-021 In COUNT, dec SHALL be driven combinationally as (zero==0).
REQ-022 In COUNT, each rising edge with zero=0 SHALL increment the internal counter.
REQ-023 In COUNT, with zero=1 and counter==captured value, the next state SHALL be DONE.
REQ-024 In COUNT, with zero=1 and counter!=captured value, the next state SHALL be ERR (early or late zero).
REQ-025 In COUNT, with zero=0 and counter==value+MARGIN, the next state SHALL be ERR (timeout); no further dec SHALL be issued.
REQ-026 The comparison in REQ-025 SHALL use 5-bit unsigned arithmetic, so value=15 with MARGIN=15 (sum 30) does not wrap.
REQ-027 In DONE, done SHALL be 1 for one cycle, with latch=0 and dec=0; the next state SHALL be IDLE.
REQ-028 In ERR, error SHALL be 1 for one cycle, with latch=0 and dec=0; the next state SHALL be IDLE.
REQ-029 done and error SHALL never both be 1 in the same cycle.
REQ-030 Outside LOAD, latch SHALL be 0; outside COUNT, dec SHALL be 0.
REQ-031 cycles SHALL be updated on entry to DONE or ERR with the final counter value, and SHALL hold that value until the next entry to DONE or ERR.
REQ-032 For a correct sequence, done SHALL be high in cycle value+4 counted from the accepting edge (the cycle starting at the accepting edge is cycle 1).
REQ-033 A request presented in the DONE or ERR cycle SHALL NOT be accepted until IDLE.
REQ-034 A back-to-back request held high SHALL be accepted on the first IDLE edge.
REQ-035 Zero=1 during LOAD or SETTLE SHALL be ignored; only COUNT SHALL sample zero.

Reset
REQ-036 Reset=1 on a rising edge SHALL force IDLE from any state, including mid-COUNT.
REQ-037 Reset SHALL set: latch=0, dec=0, done=0, error=0, busy=0, cycles=0, internal counter=0 and captured value=0.
REQ-038 While reset=1, req_ready SHALL be 0, and no request SHALL be accepted on an edge where reset=1.
REQ-039 After reset is released, req_ready SHALL be 1 in the following cycle.

Verification
REQ-040 Scenario: the bench SHALL connect a behavioural 4-bit loadable down counter, send req_value=2 -> latch one cycle, dec high 2 cycles, done pulse in cycle 6, cycles=2, error never 1.
REQ-041 Scenario: req_value=0 with the counter model -> zero=1 on COUNT entry, dec never 1, done in cycle 4, cycles=0.
REQ-042 Scenario: counter model stuck at nonzero, req_value=3, MARGIN=2 -> dec high exactly 5 cycles, error pulse, cycles=5, done stays 0.
REQ-043 Scenario: zero forced to 1 after 1 dec with req_value=4 -> error pulse, cycles=1.
REQ-044 Scenario: reset asserted in the second COUNT cycle of a req_value=9 sequence -> next cycle dec=0, busy=0, cycles=0; a new request with req_value=1 then completes with done and cycles=1.
REQ-045 Scenario: req_valid held high across two requests of 1 then 3 -> second acceptance on the first IDLE edge after DONE; outputs show two done pulses and cycles=1, then cycles=3.

Source files
------------

// File: rtl/count_sequencer.sv
// Load/count-down sequencer driving an external down counter; reports
// done on a correct count, or error on an early/late zero or a timeout.
module count_sequencer #(
  parameter int MARGIN = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_value,
  output logic       latch,
  output logic       dec,
  input  logic       zero,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] cycles
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    COUNT,
    DONE,
    ERR
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] value_q;
  logic [4:0] count_q;
  logic [4:0] limit;
  logic       accept;
  logic       finishing;

  // Five-bit sum so value 15 plus margin 15 cannot wrap.
  assign limit     = {1'b0, value_q} + 5'(MARGIN);
  assign accept    = req_valid & req_ready;
  assign finishing = (state == COUNT) && (zero || (count_q == limit));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      value_q <= 4'd0;
      count_q <= 5'd0;
      cycles  <= 5'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        value_q <= req_value;
        count_q <= 5'd0;
      end else if (dec) begin
        count_q <= count_q + 5'd1;
      end
      if (finishing) begin
        cycles <= count_q;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    latch      = 1'b0;
    dec        = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = ~reset;
        if (req_valid && !reset) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        latch      = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        state_next = COUNT;
      end
      COUNT: begin
        // Zero takes priority; the timeout suppresses the final decrement.
        if (zero) begin
          state_next = (count_q == {1'b0, value_q}) ? DONE : ERR;
        end else if (count_q == limit) begin
          state_next = ERR;
        end else begin
          dec = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        error      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: external down-counter model, per-cycle
// reference model comparison, directed scenarios and a random phase.
module tb_count_sequencer;

  localparam int MARGIN = 2;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_value;
  logic       latch;
  logic       dec;
  logic       zero;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] cycles;

  int n_compared = 0;
  int n_mismatched = 0;

  count_sequencer #(.MARGIN(MARGIN)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
    .latch     (latch),
    .dec       (dec),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cycles    (cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External counter: mode 0 real counter, 1 stuck nonzero, 2 zero after
  // force_n decrements, 3 random zero.
  int         mode = 0;
  int         force_n = 0;
  logic       rnd_zero = 1'b0;
  logic [3:0] ctr = 4'd0;
  int         fdecs = 0;

  // Reference model state, advanced once per rising edge.
  bit model_on = 1'b0;
  int m_since = 0;
  int m_decs = 0;
  int m_val = 0;
  int m_outcome = 0;
  int m_cycles = 0;

  always @(posedge clock) begin
    if (latch) begin
      ctr   <= 4'(m_val);
      fdecs <= 0;
    end else if (dec) begin
      if (ctr != 4'd0) ctr <= ctr - 4'd1;
      fdecs <= fdecs + 1;
    end
  end

  always_comb begin
    zero = rnd_zero;
    case (mode)
      0: zero = (ctr == 4'd0);
      1: zero = 1'b0;
      2: zero = (fdecs >= force_n);
      default: zero = rnd_zero;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Compare on the falling edge, then advance the model on the rising edge
  // using the inputs that were stable across that edge.
  initial begin
    logic s_reset, s_valid, s_zero;
    logic [3:0] s_value;
    forever begin
      @(negedge clock);
      s_reset = reset;
      s_valid = req_valid;
      s_zero  = zero;
      s_value = req_value;
      if (model_on) begin
        checkOutput("req_ready", int'(req_ready), int'(m_since == 0 && !s_reset));
        checkOutput("busy", int'(busy), int'(m_since != 0));
        checkOutput("latch", int'(latch), int'(m_since == 1));
        checkOutput("dec", int'(dec),
                    int'(m_since >= 3 && m_outcome == 0 && !s_zero && m_decs < m_val + MARGIN));
        checkOutput("done", int'(done), int'(m_outcome == 1));
        checkOutput("error", int'(error), int'(m_outcome == 2));
        checkOutput("cycles", int'(cycles), m_cycles);
      end
      @(posedge clock);
      if (s_reset) begin
        model_on  = 1'b1;
        m_since   = 0;
        m_decs    = 0;
        m_val     = 0;
        m_outcome = 0;
        m_cycles  = 0;
      end else if (model_on) begin
        if (m_since == 0) begin
          if (s_valid) begin
            m_since = 1;
            m_val   = int'(s_value);
            m_decs  = 0;
          end
        end else if (m_outcome != 0) begin
          m_since   = 0;
          m_outcome = 0;
        end else if (m_since < 3) begin
          m_since++;
        end else if (s_zero) begin
          m_outcome = (m_decs == m_val) ? 1 : 2;
          m_cycles  = m_decs;
        end else if (m_decs >= m_val + MARGIN) begin
          m_outcome = 2;
          m_cycles  = m_decs;
        end else begin
          m_decs++;
        end
      end
    end
  end

  task automatic runSeq(input logic [3:0] v, input int md, input int fn,
                        output int r_latch, output int r_dec,
                        output int r_done_k, output int r_err_k);
    int waited;
    r_latch  = 0;
    r_dec    = 0;
    r_done_k = -1;
    r_err_k  = -1;
    @(posedge clock); #1;
    mode      = md;
    force_n   = fn;
    req_valid = 1'b1;
    req_value = v;
    waited    = 0;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("accept_wait", int'(req_ready), 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_value = 4'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (latch) r_latch++;
      if (dec) r_dec++;
      if (done) r_done_k = k;
      if (error) r_err_k = k;
      if (done || error) break;
      @(posedge clock); #1;
    end
  endtask

  task automatic applyStimulus();
    int m;
    @(posedge clock); #1;
    reset     = ($urandom_range(0, 79) == 0);
    req_valid = 1'($urandom_range(0, 1));
    req_value = 4'($urandom);
    rnd_zero  = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 39) == 0) begin
      m       = $urandom_range(0, 5);
      mode    = (m > 3) ? 0 : m;
      force_n = $urandom_range(0, 5);
    end
  endtask

  initial begin
    int nl, nd, dk, ek, waited;
    int dks[$];
    int lks[$];
    int cvs[$];
    reset     = 1'b1;
    req_valid = 1'b0;
    req_value = 4'd0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("ready_in_reset", int'(req_ready), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("ready_after_reset", int'(req_ready), 1);
    checkOutput("busy_after_reset", int'(busy), 0);
    checkOutput("cycles_after_reset", int'(cycles), 0);

    // Value 2 with a real counter.
    runSeq(4'd2, 0, 0, nl, nd, dk, ek);
    checkOutput("v2_latch", nl, 1);
    checkOutput("v2_dec", nd, 2);
    checkOutput("v2_done_cycle", dk, 6);
    checkOutput("v2_error", ek, -1);
    checkOutput("v2_cycles", int'(cycles), 2);

    // Value 0: zero already set on entry to counting.
    runSeq(4'd0, 0, 0, nl, nd, dk, ek);
    checkOutput("v0_dec", nd, 0);
    checkOutput("v0_done_cycle", dk, 4);
    checkOutput("v0_cycles", int'(cycles), 0);

    // Stuck counter: timeout after value+MARGIN decrements.
    runSeq(4'd3, 1, 0, nl, nd, dk, ek);
    checkOutput("stuck_dec", nd, 5);
    checkOutput("stuck_error_cycle", ek, 9);
    checkOutput("stuck_done", dk, -1);
    checkOutput("stuck_cycles", int'(cycles), 5);

    // Early zero after one decrement.
    runSeq(4'd4, 2, 1, nl, nd, dk, ek);
    checkOutput("early_dec", nd, 1);
    checkOutput("early_error_cycle", ek, 5);
    checkOutput("early_cycles", int'(cycles), 1);

    // Reset in the second counting cycle of a value-9 run.
    @(posedge clock); #1;
    mode      = 0;
    req_valid = 1'b1;
    req_value = 4'd9;
    @(negedge clock);
    checkOutput("v9_ready", int'(req_ready), 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_value = 4'($urandom);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("v9_dec_before_reset", int'(dec), 1);
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("v9_dec_after_reset", int'(dec), 0);
    checkOutput("v9_busy_after_reset", int'(busy), 0);
    checkOutput("v9_cycles_after_reset", int'(cycles), 0);
    checkOutput("v9_ready_during_reset", int'(req_ready), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("v9_ready_released", int'(req_ready), 1);
    runSeq(4'd1, 0, 0, nl, nd, dk, ek);
    checkOutput("v1_done_cycle", dk, 5);
    checkOutput("v1_cycles", int'(cycles), 1);

    // req_valid held across two requests (1 then 3).
    @(posedge clock); #1;
    mode      = 0;
    req_valid = 1'b1;
    req_value = 4'd1;
    waited    = 0;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    @(posedge clock); #1;
    req_value = 4'd3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (latch) lks.push_back(k);
      if (done) begin
        dks.push_back(k);
        cvs.push_back(int'(cycles));
      end
      if (dks.size() == 2) break;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    checkOutput("b2b_done_count", dks.size(), 2);
    checkOutput("b2b_done1_cycle", (dks.size() > 0) ? dks[0] : -1, 5);
    checkOutput("b2b_done2_cycle", (dks.size() > 1) ? dks[1] : -1, 13);
    checkOutput("b2b_latch2_cycle", (lks.size() > 1) ? lks[1] : -1, 7);
    checkOutput("b2b_cycles1", (cvs.size() > 0) ? cvs[0] : -1, 1);
    checkOutput("b2b_cycles2", (cvs.size() > 1) ? cvs[1] : -1, 3);

    // Largest value with a stuck counter: limit 17 needs five bits.
    runSeq(4'd15, 1, 0, nl, nd, dk, ek);
    checkOutput("v15_dec", nd, 17);
    checkOutput("v15_error_cycle", ek, 21);
    checkOutput("v15_cycles", int'(cycles), 17);

    // Random phase; the per-cycle model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
    end
    @(posedge clock); #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
